// File: rtl/writeback.sv
// Y86 write-back stage: W pipeline register, architectural register file,
// program status, sticky halt flag and retired-instruction counter.
module writeback #(
    parameter logic [63:0] STACK_INIT = 64'd64,
    parameter int          CNT_W      = 64
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             W_stall_i,
    input  logic             W_bubble_i,
    input  logic [3:0]       m_stat_i,
    input  logic [3:0]       M_icode_i,
    input  logic [63:0]      M_valE_i,
    input  logic [63:0]      m_valM_i,
    input  logic [3:0]       M_dstE_i,
    input  logic [3:0]       M_dstM_i,
    input  logic [3:0]       d_srcA_i,
    input  logic [3:0]       d_srcB_i,
    output logic [63:0]      d_rvalA_o,
    output logic [63:0]      d_rvalB_o,
    output logic [3:0]       W_icode_o,
    output logic [3:0]       W_stat_o,
    output logic [3:0]       W_dstE_o,
    output logic [3:0]       W_dstM_o,
    output logic [63:0]      W_valE_o,
    output logic [63:0]      W_valM_o,
    output logic [3:0]       stat_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] instret_o
);

    localparam logic [3:0] SAOK = 4'd1;
    localparam logic [3:0] INOP = 4'd1;
    localparam logic [3:0] NREG = 4'hF;

    logic [3:0]       r_w_icode;
    logic [3:0]       r_w_stat;
    logic [3:0]       r_w_dste;
    logic [3:0]       r_w_dstm;
    logic [63:0]      r_w_vale;
    logic [63:0]      r_w_valm;
    logic             r_w_new;
    logic             r_halted;
    logic [CNT_W-1:0] r_instret;
    logic [63:0]      r_regs [0:14];

    logic w_freeze;
    logic w_load;
    logic w_wr_en;
    logic w_retire;

    // A faulting instruction in W freezes W at once, so nothing younger
    // ever enters W even before halted_o has risen.
    assign w_freeze = r_halted || (r_w_stat != SAOK);
    assign w_load   = !w_freeze && !W_bubble_i && !W_stall_i;
    assign w_wr_en  = (r_w_stat == SAOK);
    assign w_retire = r_w_new && (r_w_stat == SAOK) && (r_w_icode != INOP);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_w_icode <= INOP;
            r_w_stat  <= SAOK;
            r_w_dste  <= NREG;
            r_w_dstm  <= NREG;
            r_w_vale  <= '0;
            r_w_valm  <= '0;
            r_w_new   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block order.
            r_w_new <= w_load;
            if (!w_freeze) begin
                if (W_bubble_i) begin
                    r_w_icode <= INOP;
                    r_w_stat  <= SAOK;
                    r_w_dste  <= NREG;
                    r_w_dstm  <= NREG;
                    r_w_vale  <= '0;
                    r_w_valm  <= '0;
                end else if (!W_stall_i) begin
                    r_w_icode <= M_icode_i;
                    r_w_stat  <= m_stat_i;
                    r_w_dste  <= M_dstE_i;
                    r_w_dstm  <= M_dstM_i;
                    r_w_vale  <= M_valE_i;
                    r_w_valm  <= m_valM_i;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: the register file is flop-based and architecturally
            // visible, so it is reset (with %rsp preset) rather than left X.
            for (int i = 0; i < 15; i++) begin
                r_regs[i] <= (i == 4) ? STACK_INIT : 64'd0;
            end
        end else if (w_wr_en) begin
            if (r_w_dste != NREG) r_regs[r_w_dste] <= r_w_vale;
            // Last assignment wins on a shared index: valM beats valE (popq %rsp).
            if (r_w_dstm != NREG) r_regs[r_w_dstm] <= r_w_valm;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_halted  <= 1'b0;
            r_instret <= '0;
        end else begin
            if (r_w_stat != SAOK) r_halted <= 1'b1;
            if (w_retire) r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign d_rvalA_o = (d_srcA_i == NREG) ? 64'd0 : r_regs[d_srcA_i];
    assign d_rvalB_o = (d_srcB_i == NREG) ? 64'd0 : r_regs[d_srcB_i];

    assign W_icode_o = r_w_icode;
    assign W_stat_o  = r_w_stat;
    assign W_dstE_o  = r_w_dste;
    assign W_dstM_o  = r_w_dstm;
    assign W_valE_o  = r_w_vale;
    assign W_valM_o  = r_w_valm;
    // W freezes on a fault, so its status already is the terminating status.
    assign stat_o    = r_w_stat;
    assign halted_o  = r_halted;
    assign instret_o = r_instret;

endmodule

// File: doc/writeback.md
# writeback

Write-back stage of the Y86 pipelined CPU: holds the W pipeline register, owns the architectural register file and drives its two write ports (E and M) from W. It serves the decode stage with combinational read data and W forwarding values. It also produces the program status, a sticky halt flag and a retired-instruction counter.

## Interface
Parameters:
- STACK_INIT, 64, reset value of %rsp (register 4)
- CNT_W, 64, width of instret_o

Ports (name, direction, width, meaning):
- clk_i  in  1  clock; all state updates on the rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- W_stall_i  in  1  hold W register contents
- W_bubble_i  in  1  load a bubble into W
- m_stat_i  in  4  status from memory stage
- M_icode_i  in  4  icode from M
- M_valE_i  in  64  ALU result from M
- m_valM_i  in  64  memory read data
- M_dstE_i  in  4  E destination from M
- M_dstM_i  in  4  M destination from M
- d_srcA_i  in  4  read address A from decode
- d_srcB_i  in  4  read address B from decode
- d_rvalA_o  out  64  register file data for d_srcA_i
- d_rvalB_o  out  64  register file data for d_srcB_i
- W_icode_o  out  4  W register icode
- W_stat_o  out  4  W register status
- W_dstE_o, W_dstM_o  out  4 each  W destinations (forwarding/hazard)
- W_valE_o, W_valM_o  out  64 each  W values (forwarding)
- stat_o  out  4  program status
- halted_o  out  1  sticky: a non-AOK status has reached W
- instret_o  out  CNT_W  retired-instruction count

## Operation
- Encodings: SAOK=1, SHLT=2, SADR=3, SINS=4. INOP=1. NREG=4'hF.
- Register file: 15 x 64-bit registers (0..14). NREG is never stored.
- W update at each clock edge, in priority order:
  - halted_o=1: W is frozen; stall and bubble are ignored.
  - W_bubble_i=1: icode=INOP, stat=SAOK, dstE=dstM=NREG, valE=valM=0. Bubble beats stall.
  - W_stall_i=1: W holds its contents.
  - Otherwise: W loads the M-side inputs.
- Register write at each clock edge:
  - Writes are enabled only when W_stat_o==SAOK.
  - If W_dstE_o!=NREG, write W_valE_o to it.
  - If W_dstM_o!=NREG, write W_valM_o to it.
  - If dstE==dstM, the valM write wins (popq %rsp semantics).
- Read ports: combinational, no internal bypass; decode forwards from W itself. A read of NREG returns 0.
- stat_o: SAOK when W_stat_o==SAOK, else W_stat_o. Once halted, stat_o holds the terminating status.
- halted_o: set on the first edge at which W_stat_o!=SAOK; cleared only by reset.
- Retirement:
  - W_new is an internal flag, set on an edge that loads W from M (not a bubble, not a stall) and cleared otherwise.
  - instret increments by 1 on each edge where W_new=1 and W_stat_o==SAOK and W_icode_o!=INOP.
  - A stalled instruction is counted once. The counter wraps at 2^CNT_W.

## Timing
- Reset, asynchronous with rst_n_i low:
  - registers: all 0, except reg 4 = STACK_INIT
  - W: icode=INOP, stat=SAOK, dsts=NREG, vals=0
  - W_new=0, halted_o=0, instret_o=0, stat_o=SAOK
- Reset asserted mid-operation: all state returns to reset values immediately; no write completes in that cycle.
- Latency:
  - M inputs appear on W_* one cycle after capture.
  - Their register write commits at the following edge.
  - The written value is visible on d_rvalX_o from the cycle after that edge.
- Non-AOK instruction entering W: its own dsts are not written. halted_o rises one edge after it enters W; no later instruction ever enters W.
- Repeated identical writes while stalled are harmless.

## Test plan
- Reset: pulse rst_n_i low between edges -> d_rvalA_o for src 4 = 64, src 3 = 0, src NREG = 0; stat_o=1; instret_o=0.
- Normal write: M_dstE=2, M_valE=0xAA, M_dstM=NREG, stat AOK, icode 6 -> W_valE_o=0xAA after edge 1; d_rvalA_o(src 2)=0xAA after edge 2; instret_o=1.
- Dual write same register: dstE=dstM=4, valE=0x10, valM=0x20 -> reg 4 reads 0x20.
- Stall then bubble: load an instruction, hold W_stall_i for 3 cycles -> instret_o increments once. Then assert stall and bubble together -> W_icode_o=INOP, W_dstE_o=NREG.
- Halt: load m_stat=SHLT with dstE=5 -> reg 5 unchanged; halted_o=1 next edge; stat_o=2. Further M inputs and bubbles leave W and instret unchanged.
- Mid-run reset: assert rst_n_i low during a stall with halted_o=1 -> halted_o=0, stat_o=1, reg 4 = 64 immediately.
